// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, and buffers {pc, instr} pairs in a 2-entry queue for decode.
// Optional performance counters (fetch_cnt, flush_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int          N        = 64,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_data,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [31:0]  out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_t;

  count_t       state;
  logic [N-1:0] pc;
  logic [N-1:0] head_pc;
  logic [N-1:0] tail_pc;
  logic [31:0]  head_instr;
  logic [31:0]  tail_instr;
  logic         pop;

  assign imem_addr = pc;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;
  assign out_pc    = out_valid ? head_pc : '0;
  assign out_instr = out_valid ? head_instr : '0;

  // Every non-redirect cycle pushes except FULL without a pop, so the PC advances whenever a slot is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      pc         <= RESET_PC;
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else if (br_taken) begin
      state      <= EMPTY;
      pc         <= br_target & ~N'(3);
      head_pc    <= '0;
      head_instr <= '0;
      tail_pc    <= '0;
      tail_instr <= '0;
    end else begin
      case (state)
        EMPTY: begin
          head_pc    <= pc;
          head_instr <= imem_data;
          pc         <= pc + N'(4);
          state      <= ONE;
        end
        ONE: begin
          if (pop) begin
            head_pc    <= pc;
            head_instr <= imem_data;
          end else begin
            tail_pc    <= pc;
            tail_instr <= imem_data;
            state      <= FULL;
          end
          pc <= pc + N'(4);
        end
        FULL: begin
          if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= pc;
            tail_instr <= imem_data;
            pc         <= pc + N'(4);
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // A pop on a redirect edge still counts as delivered to decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)      fetch_cnt <= fetch_cnt + 32'd1;
      if (br_taken) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
